// File: rtl/qa_drv_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qa_drv_mem_arbiter                                                       |
// | Round-robin sharing of one tagged memory-driver port among N clients,    |
// | with tag-based read response routing and per-client read credit limits. |
// | Optional: define QA_DRV_MEM_ARB_STATS_EN for per-client issue counters.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module qa_drv_mem_arbiter #(
  parameter int N_CLIENTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 13,
  parameter int MAX_READS  = 32
) (
  input  logic                             clk,
  input  logic                             resetb,
  input  logic [N_CLIENTS-1:0]             cl_rd_req,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]  cl_rd_addr,
  output logic [N_CLIENTS-1:0]             cl_rd_rdy,
  input  logic [N_CLIENTS-1:0]             cl_rd_enable,
  output logic [DATA_WIDTH-1:0]            cl_rd_rsp_data,
  output logic [N_CLIENTS-1:0]             cl_rd_rsp_valid,
  input  logic [N_CLIENTS-1:0]             cl_wr_req,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0]  cl_wr_addr,
  input  logic [N_CLIENTS*DATA_WIDTH-1:0]  cl_wr_data,
  output logic [N_CLIENTS-1:0]             cl_wr_rdy,
  input  logic [N_CLIENTS-1:0]             cl_wr_enable,
  output logic [N_CLIENTS*8-1:0]           cl_rd_outstanding,
  output logic [ADDR_WIDTH-1:0]            dn_rd_req_addr,
  output logic [TAG_WIDTH-1:0]             dn_rd_req_tag,
  input  logic                             dn_rd_req_rdy,
  output logic                             dn_rd_req_enable,
  input  logic [DATA_WIDTH-1:0]            dn_rd_rsp_data,
  input  logic [TAG_WIDTH-1:0]             dn_rd_rsp_tag,
  input  logic                             dn_rd_rsp_valid,
  output logic [ADDR_WIDTH-1:0]            dn_wr_addr,
  output logic [DATA_WIDTH-1:0]            dn_wr_data,
  input  logic                             dn_wr_rdy,
  output logic                             dn_wr_enable,
  output logic [N_CLIENTS*32-1:0]          stat_rd_issued,
  output logic [N_CLIENTS*32-1:0]          stat_wr_issued
);

  localparam int              IDX_W     = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CLIENTS - 1);
  localparam logic [7:0]      READ_CAP  = 8'(MAX_READS);

  // Returns {found, index} of the first set bit at or after ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_CLIENTS-1:0] elig,
                                             input logic [IDX_W-1:0]     ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % N_CLIENTS);
      if (elig[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [IDX_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [N_CLIENTS-1:0] rd_elig;
  logic [IDX_W:0]       rd_pick, wr_pick;
  logic [IDX_W-1:0]     rd_win, wr_win;
  logic                 rd_found, wr_found;
  logic [N_CLIENTS-1:0] rd_fire_vec, wr_fire_vec;

  assign rd_pick  = rr_pick(rd_elig, rd_ptr_q);
  assign wr_pick  = rr_pick(cl_wr_req, wr_ptr_q);
  assign rd_found = rd_pick[IDX_W];
  assign rd_win   = rd_pick[IDX_W-1:0];
  assign wr_found = wr_pick[IDX_W];
  assign wr_win   = wr_pick[IDX_W-1:0];

  always_comb begin
    cl_rd_rdy = '0;
    cl_wr_rdy = '0;
    if (resetb && rd_found) cl_rd_rdy[rd_win] = dn_rd_req_rdy;
    if (resetb && wr_found) cl_wr_rdy[wr_win] = dn_wr_rdy;
  end

  // Enables without a matching grant are simply masked off here.
  assign rd_fire_vec      = cl_rd_enable & cl_rd_rdy;
  assign wr_fire_vec      = cl_wr_enable & cl_wr_rdy;
  assign dn_rd_req_enable = |rd_fire_vec;
  assign dn_wr_enable     = |wr_fire_vec;

  always_comb begin
    dn_rd_req_addr = '0;
    dn_wr_addr     = '0;
    dn_wr_data     = '0;
    dn_rd_req_tag  = '0;
    dn_rd_req_tag[IDX_W-1:0] = rd_win;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (rd_win == IDX_W'(i)) dn_rd_req_addr = cl_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (wr_win == IDX_W'(i)) begin
        dn_wr_addr = cl_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        dn_wr_data = cl_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (dn_rd_req_enable) rd_ptr_d = (rd_win == LAST_IDX) ? '0 : rd_win + 1'b1;
    if (dn_wr_enable)     wr_ptr_d = (wr_win == LAST_IDX) ? '0 : wr_win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign cl_rd_rsp_data = dn_rd_rsp_data;

  generate
    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_client
      logic [7:0] cnt_q, cnt_d;

      // Routing is not gated by reset so in-flight responses still land.
      assign cl_rd_rsp_valid[i] = dn_rd_rsp_valid && (dn_rd_rsp_tag == TAG_WIDTH'(i));
      assign rd_elig[i]         = cl_rd_req[i] && (cnt_q < READ_CAP);
      assign cl_rd_outstanding[i*8 +: 8] = cnt_q;

      always_comb begin
        cnt_d = cnt_q;
        if (rd_fire_vec[i] && !cl_rd_rsp_valid[i]) begin
          cnt_d = cnt_q + 8'd1;
        end else if (!rd_fire_vec[i] && cl_rd_rsp_valid[i] && (cnt_q != 8'd0)) begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (!resetb) cnt_q <= '0;
        else         cnt_q <= cnt_d;
      end

      a_rsp_with_credit: assert property (@(posedge clk) disable iff (!resetb)
        !(cl_rd_rsp_valid[i] && (cnt_q == 8'd0)));

`ifdef QA_DRV_MEM_ARB_STATS_EN
      logic [31:0] stat_rd_q, stat_wr_q;
      always_ff @(posedge clk) begin
        if (!resetb) begin
          stat_rd_q <= '0;
          stat_wr_q <= '0;
        end else begin
          if (rd_fire_vec[i]) stat_rd_q <= stat_rd_q + 32'd1;
          if (wr_fire_vec[i]) stat_wr_q <= stat_wr_q + 32'd1;
        end
      end
      assign stat_rd_issued[i*32 +: 32] = stat_rd_q;
      assign stat_wr_issued[i*32 +: 32] = stat_wr_q;
`else
      assign stat_rd_issued[i*32 +: 32] = '0;
      assign stat_wr_issued[i*32 +: 32] = '0;
`endif
    end
  endgenerate

  a_rd_enable_granted: assert property (@(posedge clk) disable iff (!resetb)
    (cl_rd_enable & ~cl_rd_rdy) == '0);
  a_wr_enable_granted: assert property (@(posedge clk) disable iff (!resetb)
    (cl_wr_enable & ~cl_wr_rdy) == '0);
  a_rsp_tag_in_range: assert property (@(posedge clk) disable iff (!resetb)
    !dn_rd_rsp_valid || ({1'b0, dn_rd_rsp_tag} < (TAG_WIDTH + 1)'(N_CLIENTS)));

endmodule
`default_nettype wire
